// File: rtl/network_trigger_controller_pkg.sv
// Shared definitions for the network trigger controller: sequencer state encoding.
package network_trigger_controller_pkg;

    typedef logic [1:0] net_state_t;

    localparam net_state_t NET_IDLE  = 2'd0;
    localparam net_state_t NET_START = 2'd1;
    localparam net_state_t NET_RUN   = 2'd2;
    localparam net_state_t NET_DONE  = 2'd3;

endpackage

// File: rtl/network_trigger_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the run statistics.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge ap_clk) begin
        if (ap_rst || clear) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/network_trigger_controller.sv
// Network-level sequencer: broadcasts start to all triggers, aggregates their
// sleep/sync/waited flags, detects quiescence and keeps run statistics.
module network_trigger_controller
    import network_trigger_controller_pkg::*;
#(
    parameter int unsigned NUM_TRIGGERS   = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    output logic                    ap_ready,
    output logic                    trig_start,
    input  logic [NUM_TRIGGERS-1:0] trig_idle,
    input  logic [NUM_TRIGGERS-1:0] trig_sleep,
    input  logic [NUM_TRIGGERS-1:0] trig_sync_sleep,
    input  logic [NUM_TRIGGERS-1:0] trig_waited,
    output logic                    all_sleep,
    output logic                    all_sync_sleep,
    output logic                    all_waited,
    output logic [CNT_W-1:0]        run_cycles,
    output logic [CNT_W-1:0]        sync_rounds,
    output logic                    timeout
);

    net_state_t state;
    net_state_t state_next;
    logic       in_run;
    logic       idle_all;
    logic       run_guard;
    logic       sleep_d;
    logic       sync_sleep_d;
    logic       waited_d;
    logic       wd_hit;

    assign in_run       = (state == NET_RUN);
    assign idle_all     = &trig_idle;
    assign sleep_d      = in_run & (&trig_sleep);
    assign sync_sleep_d = in_run & (&trig_sync_sleep);
    assign waited_d     = in_run & (&trig_waited);

    assign wd_hit = (TIMEOUT_CYCLES != 0) && in_run &&
                    (run_cycles == CNT_W'(TIMEOUT_CYCLES - 1));

    assign trig_start = (state == NET_START);
    assign ap_idle    = (state == NET_IDLE);
    assign ap_done    = (state == NET_DONE);
    assign ap_ready   = ap_done;

    always_comb begin
        state_next = state;
        case (state)
            NET_IDLE:  if (ap_start && idle_all) state_next = NET_START;
            NET_START: state_next = NET_RUN;
            // run_guard masks the triggers' idle-exit latency on the first run cycle
            NET_RUN:   if (idle_all && run_guard) state_next = NET_DONE;
            NET_DONE:  state_next = NET_IDLE;
            default:   state_next = NET_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state          <= NET_IDLE;
            run_guard      <= 1'b0;
            all_sleep      <= 1'b0;
            all_sync_sleep <= 1'b0;
            all_waited     <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            state          <= state_next;
            run_guard      <= in_run;
            all_sleep      <= sleep_d;
            all_sync_sleep <= sync_sleep_d;
            all_waited     <= waited_d;
            if (state == NET_START) begin
                timeout <= 1'b0;
            end else if (wd_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_run_cnt (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .clear  (state == NET_START),
        .inc    (in_run),
        .value  (run_cycles)
    );

    // counted on the edge where the aggregated sync flag rises
    sat_counter #(.W(CNT_W)) u_sync_cnt (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .clear  (state == NET_START),
        .inc    (sync_sleep_d & ~all_sync_sleep),
        .value  (sync_rounds)
    );

endmodule

// File: tb/tb_network_trigger_controller.sv
// Randomized self-checking bench: a 4-trigger controller with a 10-cycle watchdog
// and a 1-trigger, 4-bit-counter controller sharing the same stimulus.
module tb_network_trigger_controller;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 10;
    localparam int unsigned SATB = 15;

    logic ap_clk = 1'b0;
    logic ap_rst;
    logic ap_start;
    logic [N-1:0] trig_idle, trig_sleep, trig_sync_sleep, trig_waited;

    logic ap_done, ap_idle, ap_ready, trig_start;
    logic all_sleep, all_sync_sleep, all_waited, timeout;
    logic [31:0] run_cycles, sync_rounds;

    logic ap_done_b, ap_idle_b, ap_ready_b, trig_start_b;
    logic all_sleep_b, all_sync_sleep_b, all_waited_b, timeout_b;
    logic [3:0] run_cycles_b, sync_rounds_b;
    logic idle_b, sleep_b, sync_b, waited_b;

    assign idle_b   = &trig_idle;
    assign sleep_b  = trig_sleep[0];
    assign sync_b   = trig_sync_sleep[0];
    assign waited_b = trig_waited[0];

    network_trigger_controller #(.NUM_TRIGGERS(N), .CNT_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .trig_start(trig_start), .trig_idle(trig_idle), .trig_sleep(trig_sleep),
        .trig_sync_sleep(trig_sync_sleep), .trig_waited(trig_waited),
        .all_sleep(all_sleep), .all_sync_sleep(all_sync_sleep), .all_waited(all_waited),
        .run_cycles(run_cycles), .sync_rounds(sync_rounds), .timeout(timeout)
    );

    network_trigger_controller #(.NUM_TRIGGERS(1), .CNT_W(4), .TIMEOUT_CYCLES(0)) dut_b (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done_b), .ap_idle(ap_idle_b), .ap_ready(ap_ready_b),
        .trig_start(trig_start_b), .trig_idle(idle_b), .trig_sleep(sleep_b),
        .trig_sync_sleep(sync_b), .trig_waited(waited_b),
        .all_sleep(all_sleep_b), .all_sync_sleep(all_sync_sleep_b), .all_waited(all_waited_b),
        .run_cycles(run_cycles_b), .sync_rounds(sync_rounds_b), .timeout(timeout_b)
    );

    always #5 ap_clk = ~ap_clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: visible values of the aggregate flags and statistics.
    logic [2:0]  exp_all, exp_all_b;
    int unsigned exp_run, exp_rounds, exp_run_b, exp_rounds_b;
    logic        exp_tmo;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic model_clear();
        exp_all = '0; exp_all_b = '0;
        exp_run = 0; exp_rounds = 0; exp_tmo = 1'b0;
        exp_run_b = 0; exp_rounds_b = 0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0;
        trig_idle = '1; trig_sleep = '1; trig_sync_sleep = '1; trig_waited = '1;
        tick(); tick();
        ap_rst = 1'b0;
        model_clear();
        compared++;
        if ({trig_start, ap_idle, ap_done, ap_ready, all_sleep, all_sync_sleep, all_waited, timeout} !== 8'b0100_0000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want 01000000",
                {trig_start, ap_idle, ap_done, ap_ready, all_sleep, all_sync_sleep, all_waited, timeout});
        end
        compared++;
        if (run_cycles !== 32'd0 || sync_rounds !== 32'd0 || run_cycles_b !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_counters: got run=%0d sync=%0d run_b=%0d want 0", run_cycles, sync_rounds, run_cycles_b);
        end
    endtask

    // One complete host transaction; mode 0 random flags, 1 sync pattern, 2 sleep/waited held high.
    task automatic do_run(input int unsigned n_block, input int unsigned busy,
                          input int unsigned mode, output int unsigned rounds_out);
        int unsigned r_len, total, k, ph;
        logic [3:0]  exp_ctrl;
        logic [2:0]  nxt;
        logic        nb;
        r_len = (busy + 1 < 2) ? 2 : busy + 1;
        total = n_block + r_len + 4;
        for (int unsigned i = 0; i < total; i++) begin
            k = 0;
            if (i <= n_block) ph = 0;
            else if (i == n_block + 1) ph = 1;
            else if (i <= n_block + 1 + r_len) begin ph = 2; k = i - n_block - 1; end
            else if (i == n_block + 2 + r_len) ph = 3;
            else ph = 0;
            exp_ctrl = (ph == 0) ? 4'b0100 : (ph == 1) ? 4'b1000 : (ph == 2) ? 4'b0000 : 4'b0011;

            compared++;
            if ({trig_start, ap_idle, ap_done, ap_ready} !== exp_ctrl) begin
                mismatched++;
                $display("FAIL ctrl[%0d]: got %b want %b", i, {trig_start, ap_idle, ap_done, ap_ready}, exp_ctrl);
            end
            compared++;
            if ({all_sleep, all_sync_sleep, all_waited} !== exp_all) begin
                mismatched++;
                $display("FAIL all_flags[%0d]: got %b want %b", i, {all_sleep, all_sync_sleep, all_waited}, exp_all);
            end
            compared++;
            if (run_cycles !== exp_run || sync_rounds !== exp_rounds || timeout !== exp_tmo) begin
                mismatched++;
                $display("FAIL stats[%0d]: got run=%0d sync=%0d tmo=%b want run=%0d sync=%0d tmo=%b",
                    i, run_cycles, sync_rounds, timeout, exp_run, exp_rounds, exp_tmo);
            end
            compared++;
            if ({trig_start_b, ap_idle_b, ap_done_b, ap_ready_b} !== exp_ctrl ||
                {all_sleep_b, all_sync_sleep_b, all_waited_b} !== exp_all_b) begin
                mismatched++;
                $display("FAIL single_flags[%0d]: got ctrl=%b all=%b want ctrl=%b all=%b", i,
                    {trig_start_b, ap_idle_b, ap_done_b, ap_ready_b},
                    {all_sleep_b, all_sync_sleep_b, all_waited_b}, exp_ctrl, exp_all_b);
            end
            compared++;
            if (run_cycles_b !== 4'(exp_run_b) || sync_rounds_b !== 4'(exp_rounds_b) || timeout_b !== 1'b0) begin
                mismatched++;
                $display("FAIL single_stats[%0d]: got run=%0d sync=%0d tmo=%b want run=%0d sync=%0d tmo=0",
                    i, run_cycles_b, sync_rounds_b, timeout_b, exp_run_b, exp_rounds_b);
            end
            if (i == total - 1) break;

            ap_start = 1'b1;
            if (i < n_block) trig_idle = (i == 0) ? 4'b1011 : 4'($urandom_range(0, 14));
            else if (ph == 1) trig_idle = 4'($urandom);
            else if (ph == 2 && k <= busy) trig_idle = 4'($urandom_range(0, 14));
            else trig_idle = '1;
            trig_sleep      = ($urandom_range(0, 1) == 1) ? '1 : 4'($urandom);
            trig_sync_sleep = ($urandom_range(0, 1) == 1) ? '1 : 4'($urandom);
            trig_waited     = ($urandom_range(0, 1) == 1) ? '1 : 4'($urandom);
            if (mode == 1) trig_sync_sleep = (ph == 1 || (ph == 2 && k <= 15 && ((k - 1) / 3) % 2 == 0)) ? '1 : '0;
            if (mode == 2) begin
                trig_sleep  = (ph == 2 && k >= 5) ? 4'b1011 : 4'b1111;
                trig_waited = '1;
            end

            nxt = {&trig_sleep, &trig_sync_sleep, &trig_waited};
            nb  = (ph == 2);
            if (ph == 1) begin
                exp_run = 0; exp_rounds = 0; exp_tmo = 1'b0;
                exp_run_b = 0; exp_rounds_b = 0;
            end
            if (ph == 2) begin
                if (nxt[1] && !exp_all[1]) exp_rounds++;
                if (trig_sync_sleep[0] && !exp_all_b[1] && exp_rounds_b < SATB) exp_rounds_b++;
                exp_run++;
                if (exp_run >= TMO) exp_tmo = 1'b1;
                if (exp_run_b < SATB) exp_run_b++;
            end
            exp_all   = nb ? nxt : 3'b000;
            exp_all_b = nb ? {trig_sleep[0], trig_sync_sleep[0], trig_waited[0]} : 3'b000;
            tick();
        end
        ap_start = 1'b0;
        rounds_out = exp_rounds;
    endtask

    task automatic test_basic_run();
        int unsigned r;
        do_run(0, 20, 0, r);
        compared++;
        if (run_cycles !== 32'd21) begin
            mismatched++;
            $display("FAIL basic_run_len: got %0d want 21", run_cycles);
        end
    endtask

    task automatic test_start_blocked();
        int unsigned r;
        do_run(3, 4, 0, r);
    endtask

    task automatic test_gating();
        int unsigned r;
        trig_sleep = '1; trig_waited = '1;
        tick();
        do_run(1, 12, 2, r);
    endtask

    task automatic test_sync_rounds();
        int unsigned r;
        do_run(0, 15, 1, r);
        compared++;
        if (sync_rounds !== 32'd3 || r != 3) begin
            mismatched++;
            $display("FAIL sync_rounds_total: got %0d want 3", sync_rounds);
        end
    endtask

    task automatic test_watchdog();
        int unsigned r;
        do_run(0, 8, 0, r);
        compared++;
        if (timeout !== 1'b0) begin
            mismatched++;
            $display("FAIL wd_9_cycles: got %b want 0", timeout);
        end
        do_run(0, 9, 0, r);
        compared++;
        if (timeout !== 1'b1) begin
            mismatched++;
            $display("FAIL wd_10_cycles: got %b want 1", timeout);
        end
        do_run(0, 14, 0, r);
        do_run(0, 3, 0, r);
        compared++;
        if (timeout !== 1'b0) begin
            mismatched++;
            $display("FAIL wd_cleared: got %b want 0", timeout);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned r;
        do_run(0, 0, 0, r);
        for (int j = 0; j < 8; j++) do_run($urandom_range(0, 2), $urandom_range(0, 25), 0, r);
    endtask

    task automatic test_reset_mid_run();
        ap_start = 1'b1; trig_idle = '1;
        trig_sleep = '1; trig_sync_sleep = '1; trig_waited = '1;
        tick();
        trig_idle = '0;
        for (int j = 0; j < 13; j++) tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0; ap_start = 1'b0; trig_idle = '1;
        model_clear();
        compared++;
        if ({trig_start, ap_idle, ap_done, all_sleep, all_sync_sleep, all_waited, timeout} !== 7'b0100000) begin
            mismatched++;
            $display("FAIL midrun_reset_ctrl: got %b want 0100000",
                {trig_start, ap_idle, ap_done, all_sleep, all_sync_sleep, all_waited, timeout});
        end
        compared++;
        if (run_cycles !== 32'd0 || sync_rounds !== 32'd0 || run_cycles_b !== 4'd0 || all_sleep_b !== 1'b0) begin
            mismatched++;
            $display("FAIL midrun_reset_stats: got run=%0d sync=%0d run_b=%0d sleep_b=%b want all 0",
                run_cycles, sync_rounds, run_cycles_b, all_sleep_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_start_blocked();
        test_gating();
        test_sync_rounds();
        test_watchdog();
        test_back_to_back();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/network_trigger_controller.md
Name: network_trigger_controller

Overview:
Network-level sequencer that sits directly above a set of per-actor pipelined triggers. It broadcasts the start pulse to every trigger and AND-reduces their sleep/sync_sleep/waited flags into registered all_sleep/all_sync_sleep/all_waited feedback. It detects network quiescence (all triggers back in idle) and reports ap_ctrl_hs done/ready to the host. It also keeps run statistics: cycle count, sync-round count and a watchdog flag.

Parameters:
NUM_TRIGGERS, 4, number of attached triggers (>=1)
CNT_W, 32, width of the statistics counters
TIMEOUT_CYCLES, 0, watchdog threshold in run cycles; 0 disables the watchdog

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
ap_start  in  1  host start (ap_ctrl_hs, held by the host until ap_ready)
ap_done  out  1  one-cycle pulse at end of run
ap_idle  out  1  high in NET_IDLE
ap_ready  out  1  equal to ap_done
trig_start  out  1  broadcast ap_start to all triggers
trig_idle  in  NUM_TRIGGERS  per-trigger ap_idle
trig_sleep  in  NUM_TRIGGERS  per-trigger sleep
trig_sync_sleep  in  NUM_TRIGGERS  per-trigger sync_sleep
trig_waited  in  NUM_TRIGGERS  per-trigger waited
all_sleep  out  1  registered AND of trig_sleep, gated
all_sync_sleep  out  1  registered AND of trig_sync_sleep, gated
all_waited  out  1  registered AND of trig_waited, gated
run_cycles  out  CNT_W  cycles spent in NET_RUN, last run
sync_rounds  out  CNT_W  0->1 transitions of all_sync_sleep, last run
timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (ap_rst=1 at posedge): state NET_IDLE. trig_start, ap_done, ap_ready, all_*, timeout and counters all 0. ap_idle=1 the cycle after reset. Reset mid-run aborts immediately with identical values; trigger resets are external.
- State machine:
  - NET_IDLE: if ap_start & (&trig_idle), go to NET_START. Otherwise stay. A start is not accepted while any trigger is non-idle.
  - NET_START: exactly one cycle. trig_start=1, so all triggers sample it in the same cycle. Clear run_cycles, sync_rounds and timeout. Go to NET_RUN.
  - NET_RUN: run_cycles increments each cycle, saturating at all-ones. When &trig_idle is 1 and the state has been NET_RUN for at least 2 cycles, go to NET_DONE. The 2-cycle guard masks the triggers' idle-exit latency.
  - NET_DONE: ap_done=ap_ready=1 for one cycle. Go to NET_IDLE. Counters hold until the next NET_START.
- Aggregation:
  - Each all_X register loads (state==NET_RUN) & (&trig_X) every cycle, giving 1-cycle latency.
  - all_X is therefore 0 during NET_START, 0 on the first NET_RUN cycle, and 0 in the cycle after leaving NET_RUN.
  - Gating prevents stale idle-state sleep=1/waited=1 from leaking into a new run.
- sync_rounds increments in NET_RUN when the all_sync_sleep register goes 0->1. The increment saturates.
- Watchdog:
  - If TIMEOUT_CYCLES!=0 and run_cycles==TIMEOUT_CYCLES-1 while in NET_RUN, timeout is set.
  - timeout is sticky until NET_START or reset.
  - The run is not aborted.
- Simultaneous events: ap_start in NET_DONE is ignored; the host sees ap_ready and must re-present ap_start. &trig_idle falling during NET_START has no effect.
- NUM_TRIGGERS=1: reductions degenerate to pass-through registers.

Decomposition:
- Add a NetState enum (NET_IDLE, NET_START, NET_RUN, NET_DONE) to the TriggerCommon package next to State and WAIT.
- One sub-module, sat_counter: parameter W; ports clear, inc; output value; saturating; used for both counters.

Test Plan:
- Reset mid-run: ap_rst pulsed during NET_RUN -> next cycle ap_idle=1, trig_start=0, all_*=0, run_cycles=0.
- Basic run, NUM_TRIGGERS=4, trig_idle deasserts 1 cycle after trig_start and returns high 20 cycles later -> trig_start high exactly 1 cycle; ap_done high 1 cycle; run_cycles=21 (+/-0 per spec count); ap_idle back next cycle.
- Start blocked: ap_start=1 while trig_idle=4'b1011 -> trig_start stays 0; once trig_idle=4'b1111, trig_start pulses next cycle.
- Gating and latency: trig_sleep=4'b1111 and trig_waited=4'b1111 held through start -> all_sleep=0 during NET_START and the first NET_RUN cycle, 1 on the second NET_RUN cycle. Then trig_sleep[2]=0 -> all_sleep=0 one cycle later.
- Sync rounds: all trig_sync_sleep toggled 1,0,1,0,1 (3-cycle phases) during the run -> sync_rounds=3 at ap_done; it holds after return to NET_IDLE.
- Watchdog: TIMEOUT_CYCLES=10, triggers stay busy for 15 cycles -> timeout rises after 10 run cycles and stays 1 through ap_done; it clears on the next trig_start cycle.
